// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// grant identifiers and default parameter widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_WORDS = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_EXT = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker (purely combinational).
//   elig_i : eligible requesters, bit 0 = CPU, bit 1 = EXT
//   lst_i  : requester granted most recently
//   vld_o  : at least one requester eligible
//   gnt_o  : chosen requester (meaningful only when vld_o = 1)
module mem_arb_rr
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] elig_i,
  input  gnt_e       lst_i,
  output logic       vld_o,
  output gnt_e       gnt_o
);

  always_comb begin
    vld_o = |elig_i;
    gnt_o = GNT_CPU;
    case (elig_i)
      2'b01:   gnt_o = GNT_CPU;
      2'b10:   gnt_o = GNT_EXT;
      // Tie: whoever did not win last time.
      2'b11:   gnt_o = (lst_i == GNT_CPU) ? GNT_EXT : GNT_CPU;
      default: gnt_o = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a loader/debug (EXT) port onto one
// synchronous-read memory. Each access takes IDLE/RESP -> ACC -> RESP:
// the memory strobe is issued in ACC and the requester's ack in RESP.
//   clk, reset            : clock, synchronous active-low reset
//   cpu_* / ext_*         : requester ports (req/we/addr/wdata in,
//                           ack/err/rdata out), cpu_stall for the CPU
//   ext_lock              : blocks new CPU grants
//   mem_addr/we/re/wdata  : word-addressed memory strobes (registered)
//   mem_rdata             : memory read data, valid the cycle after mem_re
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic              ext_err,
  output logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_lock,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  gnt_e              gnt_q, lst_q;
  logic              we_q, ok_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q, mem_re_q;
  logic              cpu_ack_q, cpu_err_q, ext_ack_q, ext_err_q;
  logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

  logic [1:0]        elig;
  logic              pick_vld;
  gnt_e              pick;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we, sel_ok;
  logic [DATA_W-1:0] sel_wdata;

  // In RESP the port being acked is excluded so the other side gets a turn.
  always_comb begin
    elig = '0;
    case (state_q)
      ST_IDLE: elig = {ext_req, cpu_req & ~ext_lock};
      ST_RESP: elig = (gnt_q == GNT_CPU) ? {ext_req, 1'b0}
                                         : {1'b0, cpu_req & ~ext_lock};
      default: elig = '0;
    endcase
  end

  mem_arb_rr u_rr (
    .elig_i (elig),
    .lst_i  (lst_q),
    .vld_o  (pick_vld),
    .gnt_o  (pick)
  );

  assign sel_addr  = (pick == GNT_EXT) ? ext_addr  : cpu_addr;
  assign sel_we    = (pick == GNT_EXT) ? ext_we    : cpu_we;
  assign sel_wdata = (pick == GNT_EXT) ? ext_wdata : cpu_wdata;
  // Misaligned addresses are rejected like out-of-range ones.
  assign sel_ok    = (sel_addr[1:0] == 2'b00) &&
                     ({2'b00, sel_addr[ADDR_W-1:2]} < ADDR_W'(MEM_WORDS));

  // Range check and strobes are resolved at grant time so the strobes can
  // be registered and still appear in the ACC cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_CPU;
      lst_q       <= GNT_EXT;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      ext_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      ext_err_q   <= 1'b0;
      cpu_rdata_q <= cpu_rdata;
      ext_rdata_q <= ext_rdata;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (pick_vld) begin
            gnt_q       <= pick;
            lst_q       <= pick;
            we_q        <= sel_we;
            ok_q        <= sel_ok;
            mem_addr_q  <= sel_addr[ADDR_W-1:2];
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_ok & sel_we;
            mem_re_q    <= sel_ok & ~sel_we;
            state_q     <= ST_ACC;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (gnt_q == GNT_CPU) begin
            cpu_ack_q <= 1'b1;
            cpu_err_q <= ~ok_q;
          end else begin
            ext_ack_q <= 1'b1;
            ext_err_q <= ~ok_q;
          end
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data comes straight from the memory in the ack cycle; otherwise
  // the last delivered value is held.
  assign cpu_rdata = (cpu_ack_q && ok_q && !we_q) ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = (ext_ack_q && ok_q && !we_q) ? mem_rdata : ext_rdata_q;

  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign ext_ack   = ext_ack_q;
  assign ext_err   = ext_err_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, cpu_err, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_ack, ext_err;
  logic [DW-1:0] ext_rdata;
  logic          ext_lock = 1'b0;
  logic [AW-3:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  logic [DW-1:0] tbmem  [MW];
  logic [DW-1:0] shadow [MW];
  logic          mem_clr = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_err(ext_err), .ext_rdata(ext_rdata), .ext_lock(ext_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MW; i++) tbmem[i] <= '0;
    end else begin
      if (mem_re) mem_rdata <= tbmem[mem_addr[7:0]];
      if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ext_drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ext_lock = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, '0);
    ext_drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[AW-1:2]} < 32'(MW));
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int unsigned k;
    logic [AW-1:0] r;
    k = $urandom_range(0, 9);
    case (k)
      0:       r = AW'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      1:       r = AW'(MW * 4 + $urandom_range(0, 63) * 4);
      2:       r = AW'($urandom);
      default: r = AW'($urandom_range(0, 31) * 4);
    endcase
    return r;
  endfunction

  // Random-phase model state, index 0 = CPU, 1 = EXT.
  logic          pend [2];
  logic [AW-1:0] ra   [2];
  logic          rwe  [2];
  logic [DW-1:0] rwd  [2];
  logic [DW-1:0] last [2];
  int unsigned   wcnt [2];
  logic [1:0]    prev_stb;
  logic [AW-3:0] prev_maddr;
  logic [DW-1:0] prev_wd;

  initial begin
    int unsigned seen;
    logic        acks [2];
    logic        errs [2];
    logic [DW-1:0] rds [2];
    logic        ok;
    bit          pi;

    for (int i = 0; i < MW; i++) shadow[i] = '0;
    do_reset();
    mem_clr = 1'b0;

    // Reset state.
    chk("rst_cpu_ack",   64'(cpu_ack),   64'(0));
    chk("rst_ext_ack",   64'(ext_ack),   64'(0));
    chk("rst_cpu_err",   64'(cpu_err),   64'(0));
    chk("rst_strobes",   64'({mem_we, mem_re}), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));

    // CPU write 0x10 <- DEADBEEF.
    cpu_drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("wr_strobe",  64'({mem_we, mem_re}), 64'(2'b10));
    chk("wr_maddr",   64'(mem_addr),  64'(4));
    chk("wr_wdata",   64'(mem_wdata), 64'h0000_0000_DEAD_BEEF);
    chk("wr_stall",   64'(cpu_stall), 64'(1));
    tick();
    chk("wr_ack",     64'({cpu_ack, cpu_err}), 64'(2'b10));
    chk("wr_nostall", 64'(cpu_stall), 64'(0));
    cpu_drive(1'b0, 1'b0, '0, '0);
    shadow[4] = 32'hDEADBEEF;
    tick();
    chk("wr_ack_pulse", 64'(cpu_ack), 64'(0));

    // CPU read 0x10: strobe at N+1, ack/data at N+2.
    cpu_drive(1'b1, 1'b0, 32'h10, '0);
    tick();
    chk("rd_strobe", 64'({mem_we, mem_re}), 64'(2'b01));
    chk("rd_maddr",  64'(mem_addr), 64'(4));
    chk("rd_early_ack", 64'(cpu_ack), 64'(0));
    tick();
    chk("rd_ack",   64'({cpu_ack, cpu_err}), 64'(2'b10));
    chk("rd_data",  64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("rd_hold",  64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);

    // Simultaneous requests after reset: CPU wins the first tie.
    do_reset();
    cpu_drive(1'b1, 1'b0, 32'h10, '0);
    ext_drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    tick();
    chk("tie_cpu_strobe", 64'({mem_we, mem_re, mem_addr}), 64'({2'b01, 30'd4}));
    tick();
    chk("tie_acks_n2",  64'({cpu_ack, ext_ack}), 64'(2'b10));
    chk("tie_cpu_data", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("tie_ext_strobe", 64'({mem_we, mem_re, mem_addr}), 64'({2'b10, 30'd8}));
    chk("tie_ext_wdata",  64'(mem_wdata), 64'h0000_0000_1234_5678);
    tick();
    chk("tie_acks_n4", 64'({cpu_ack, ext_ack, ext_err}), 64'(3'b010));
    ext_drive(1'b0, 1'b0, '0, '0);
    shadow[8] = 32'h1234_5678;
    tick();

    // Out-of-range and misaligned CPU writes.
    cpu_drive(1'b1, 1'b1, 32'(MW * 4), 32'h0BAD);
    tick();
    chk("oor_no_strobe", 64'({mem_we, mem_re}), 64'(0));
    tick();
    chk("oor_ack_err", 64'({cpu_ack, cpu_err}), 64'(2'b11));
    chk("oor_rdata_hold", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    cpu_drive(1'b1, 1'b1, 32'h3, 32'h0BAD);
    tick();
    chk("mis_no_strobe", 64'({mem_we, mem_re}), 64'(0));
    tick();
    chk("mis_ack_err", 64'({cpu_ack, cpu_err}), 64'(2'b11));
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Highest in-range word on the EXT port.
    ext_drive(1'b1, 1'b0, 32'((MW - 1) * 4), '0);
    tick();
    chk("top_strobe", 64'({mem_we, mem_re, mem_addr}), 64'({2'b01, 30'(MW - 1)}));
    tick();
    chk("top_ack", 64'({ext_ack, ext_err}), 64'(2'b10));
    chk("top_data", 64'(ext_rdata), 64'(shadow[MW-1]));
    ext_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Lock held: only EXT completes; release lets CPU through promptly.
    ext_lock = 1'b1;
    cpu_drive(1'b1, 1'b1, 32'h40, 32'hAAAA_0001);
    ext_drive(1'b1, 1'b1, 32'h44, 32'hBBBB_0002);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lock_no_cpu_ack", 64'(cpu_ack), 64'(0));
      if (ext_ack) begin
        seen++;
        ext_drive(1'b0, 1'b0, '0, '0);
      end
    end
    chk("lock_ext_acks", 64'(seen), 64'(1));
    shadow[17] = 32'hBBBB_0002;
    ext_lock = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 && seen == 0; i++) begin
      tick();
      if (cpu_ack) seen = 1;
    end
    chk("unlock_cpu_ack", 64'(seen), 64'(1));
    cpu_drive(1'b0, 1'b0, '0, '0);
    shadow[16] = 32'hAAAA_0001;
    tick();

    // Lock rising during an in-flight CPU read does not abort it.
    cpu_drive(1'b1, 1'b0, 32'h40, '0);
    tick();
    ext_lock = 1'b1;
    tick();
    chk("lock_inflight_ack",  64'(cpu_ack), 64'(1));
    chk("lock_inflight_data", 64'(cpu_rdata), 64'h0000_0000_AAAA_0001);
    cpu_drive(1'b0, 1'b0, '0, '0);
    ext_lock = 1'b0;
    tick();

    // Request dropped after grant still completes.
    cpu_drive(1'b1, 1'b0, 32'h44, '0);
    tick();
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("drop_ack",  64'(cpu_ack), 64'(1));
    chk("drop_data", 64'(cpu_rdata), 64'h0000_0000_BBBB_0002);
    tick();

    // Reset in the ACC cycle of a CPU write.
    cpu_drive(1'b1, 1'b1, 32'h80, 32'h0000_CAFE);
    tick();
    chk("rstacc_strobe", 64'({mem_we, mem_re}), 64'(2'b10));
    reset = 1'b0;
    tick();
    chk("rstacc_no_ack",    64'(cpu_ack), 64'(0));
    chk("rstacc_no_strobe", 64'({mem_we, mem_re}), 64'(0));
    reset = 1'b1;
    shadow[32] = 32'h0000_CAFE;
    cpu_drive(1'b1, 1'b0, 32'h80, '0);
    ext_drive(1'b1, 1'b0, 32'h84, '0);
    tick();
    chk("rstacc_tie_cpu", 64'({mem_re, mem_addr}), 64'({1'b1, 30'd32}));
    tick();
    chk("rstacc_tie_ack",  64'({cpu_ack, ext_ack}), 64'(2'b10));
    chk("rstacc_tie_data", 64'(cpu_rdata), 64'h0000_0000_0000_CAFE);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("rstacc_ext_ack", 64'(ext_ack), 64'(1));
    ext_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pi = 1'(p);
      pend[pi] = 1'b0; last[pi] = '0; wcnt[pi] = 0;
      ra[pi] = '0; rwe[pi] = 1'b0; rwd[pi] = '0;
    end
    prev_stb = '0; prev_maddr = '0; prev_wd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      acks[0] = cpu_ack;   acks[1] = ext_ack;
      errs[0] = cpu_err;   errs[1] = ext_err;
      rds[0]  = cpu_rdata; rds[1]  = ext_rdata;
      chk("excl_strobe", 64'(mem_we & mem_re), 64'(0));
      chk("single_ack",  64'(cpu_ack & ext_ack), 64'(0));
      for (int p = 0; p < 2; p++) begin
        pi = 1'(p);
        if (acks[pi]) begin
          ok = addr_ok(ra[pi]);
          chk("ack_pending", 64'(pend[pi]), 64'(1));
          chk("ack_err", 64'(errs[pi]), 64'(!ok));
          chk("ack_strobe", 64'(prev_stb), ok ? (rwe[pi] ? 64'(2'b10) : 64'(2'b01)) : 64'(0));
          if (ok) begin
            chk("ack_maddr", 64'(prev_maddr), 64'(ra[pi][AW-1:2]));
            if (rwe[pi]) begin
              chk("ack_wdata", 64'(prev_wd), 64'(rwd[pi]));
              shadow[ra[pi][9:2]] = rwd[pi];
            end else begin
              last[pi] = shadow[ra[pi][9:2]];
            end
          end
          chk("ack_rdata", 64'(rds[pi]), 64'(last[pi]));
          pend[pi] = 1'b0;
          wcnt[pi] = 0;
        end else if (pend[pi]) begin
          if (pi || !ext_lock) wcnt[pi]++;
          if (wcnt[pi] > 12) begin
            chk("wait_bound", 64'(wcnt[pi]), 64'(12));
            pend[pi] = 1'b0;
            wcnt[pi] = 0;
          end
        end
      end
      prev_stb   = {mem_we, mem_re};
      prev_maddr = mem_addr;
      prev_wd    = mem_wdata;

      if (cyc % 8 == 0) ext_lock = (cyc < 2700) ? ($urandom_range(0, 2) == 0) : 1'b0;
      for (int p = 0; p < 2; p++) begin
        pi = 1'(p);
        if (!pend[pi] && cyc < 2900 && $urandom_range(0, 2) == 0) begin
          pend[pi] = 1'b1;
          ra[pi]   = rand_addr();
          rwe[pi]  = 1'($urandom_range(0, 1));
          rwd[pi]  = $urandom;
        end
      end
      cpu_drive(pend[0], rwe[0], ra[0], rwd[0]);
      ext_drive(pend[1], rwe[1], ra[1], rwd[1]);
    end
    chk("drained", 64'({pend[0], pend[1]}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of both requester ports.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter MEM_WORDS, default 256, number of words in the shared memory.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous active-low reset, sampled on posedge clk, 0 = reset.
REQ-006 cpu_req / cpu_we  in  1/1  CPU access request, write when 1.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W/DATA_W  CPU byte address, write data.
REQ-008 cpu_ack / cpu_err  out  1/1  one-cycle completion pulse; err marks out-of-range.
REQ-009 cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle.
REQ-010 cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), holds the controller's state.
REQ-011 ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_err, ext_rdata: same widths and meanings as the cpu_* ports, for the loader/debug port.
REQ-012 ext_lock  in  1  when 1, no new CPU grant is issued.
REQ-013 mem_addr  out  ADDR_W-2  word address; mem_we / mem_re  out  1/1  strobes; mem_wdata  out  DATA_W.
REQ-014 mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_re.

Function
REQ-015 Handshake: requester holds req, we, addr, wdata stable until it sees ack; ack pulses exactly one cycle per accepted request.
REQ-016 FSM states: IDLE, ACC, RESP; grant register gnt in {CPU, EXT}; last-grant register lst.
REQ-017 IDLE: if any eligible req, latch gnt and the granted port's addr/we/wdata into registers, go to ACC; else stay.
REQ-018 Eligibility: ext_req always; cpu_req only when ext_lock = 0.
REQ-019 Both eligible: grant the one != lst (round-robin); lst updates on every grant.
REQ-020 ACC: in-range address -> drive mem_addr = addr[ADDR_W-1:2], mem_re = ~we, mem_we = we for exactly this cycle; go to RESP.
REQ-021 Out of range (addr[ADDR_W-1:2] >= MEM_WORDS): no mem strobe; err flag set; go to RESP.
REQ-022 Misaligned address (addr[1:0] != 0) is treated as out of range.
REQ-023 RESP: pulse gnt's ack; err equals flag; rdata = mem_rdata for in-range reads, else rdata holds previous value.
REQ-024 RESP arbitration: only the non-granted requester is eligible (per REQ-018); if eligible, grant it and go to ACC, else IDLE.
REQ-025 Latency: req seen in IDLE cycle N -> mem strobe N+1 -> ack N+2; back-to-back alternate grants every 2 cycles.
REQ-026 ext_lock rising during an in-flight CPU access does not abort it; CPU ack still issued.
REQ-027 req dropped before ack (protocol violation): in-flight access still completes and ack is still pulsed.
REQ-028 mem_we and mem_re never both 1; at most one strobe per grant.

Reset
REQ-029 reset = 0 at a clock edge: state = IDLE, lst = EXT (CPU wins first tie), all ack/err/strobes 0, rdata and mem_* registers 0.
REQ-030 Reset mid-access aborts it: no ack issued, no memory strobe in the following cycle.

Structure
REQ-031 Shared package holds FSM state encoding, grant IDs CPU/EXT, and default widths.
REQ-032 One sub-module, mem_arb_rr: 2-way round-robin pick from (eligible vector, lst) -> gnt; purely combinational.
REQ-033 All outputs except cpu_stall and ext_stall-free paths are driven from registers; target 120-400 RTL lines.

Verification
REQ-034 Single CPU read addr 0x10, mem word 4 = 0xDEADBEEF -> mem_re at N+1 with mem_addr 4, cpu_ack and cpu_rdata 0xDEADBEEF at N+2.
REQ-035 cpu_req and ext_req both rise after reset -> CPU acked first (N+2), EXT mem strobe N+3, ext_ack N+4.
REQ-036 ext_lock = 1 with both requesting writes -> only EXT writes complete; releasing lock -> CPU granted within 2 cycles.
REQ-037 CPU write addr MEM_WORDS*4, then addr 0x3 -> no mem strobe, cpu_ack with cpu_err = 1 both times.
REQ-038 reset = 0 in the ACC cycle of a CPU write -> no cpu_ack, state IDLE, next grant CPU on tie.
